// File: rtl/hc595_chain_rx.sv
// hc595_chain_rx -- behavioural receive side of a two-device 74HC595 chain.
//
// Oversamples the driver's SCK/SER/RCK lines on the system clock, shifts
// and latches like the real chain does, then decodes each latched word
// (active-low one-hot digit select in the upper byte, segments in the
// lower byte) into a per-digit segment memory.
//
// Ports:
//   clk_in       system clock
//   rst_n_in     asynchronous active-low reset
//   sclk_in      595 SCK (asynchronous)
//   sdio_in      595 SER
//   rclk_in      595 RCK (asynchronous)
//   shift_q      current shift-register contents
//   par_out      storage-register contents
//   latch_pulse  one-cycle pulse when par_out updates
//   digit_upd    one-cycle pulse when a digit slot is written
//   digit_idx    index of the last written slot
//   digits_out   segment memory, slot i at [SEG_BITS*i +: SEG_BITS]
//   frame_err    last frame's bit count differed from CHAIN_BITS
//   err_cnt      saturating count of bad frames

// Per-line synchronizer plus previous-sample flop for rising-edge detect.
module hc595_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic d,
  output logic q,
  output logic rise
);
  logic [STAGES-1:0] pipe;
  logic              prev;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pipe <= '0;
      prev <= 1'b0;
    end else begin
      pipe <= {pipe[STAGES-2:0], d};
      prev <= pipe[STAGES-1];
    end
  end

  assign q    = pipe[STAGES-1];
  assign rise = pipe[STAGES-1] & ~prev;
endmodule

module hc595_chain_rx #(
  parameter int SEG_BITS    = 8,
  parameter int SEL_BITS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                               clk_in,
  input  logic                               rst_n_in,
  input  logic                               sclk_in,
  input  logic                               sdio_in,
  input  logic                               rclk_in,
  output logic [SEL_BITS+SEG_BITS-1:0]       shift_q,
  output logic [SEL_BITS+SEG_BITS-1:0]       par_out,
  output logic                               latch_pulse,
  output logic                               digit_upd,
  output logic [$clog2(SEL_BITS)-1:0]        digit_idx,
  output logic [SEL_BITS*SEG_BITS-1:0]       digits_out,
  output logic                               frame_err,
  output logic [7:0]                         err_cnt
);
  localparam int CHAIN_BITS = SEL_BITS + SEG_BITS;
  localparam int IDX_W      = $clog2(SEL_BITS);
  localparam int CNT_W      = IDX_W + 1;

  // Line order in the sync array: 0 = sclk, 1 = sdio, 2 = rclk. All three
  // share the same depth so sdio is aligned with the sclk edge it belongs to.
  logic [2:0] lines, syncd, rise;
  assign lines = {rclk_in, sdio_in, sclk_in};

  hc595_sync #(.STAGES(SYNC_STAGES)) u_sync [2:0] (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .d        (lines),
    .q        (syncd),
    .rise     (rise)
  );

  logic sclk_rise, rclk_rise, sdio_s;
  assign sclk_rise = rise[0];
  assign sdio_s    = syncd[1];
  assign rclk_rise = rise[2];

  logic [7:0] bit_cnt;
  logic       bad_len;
  assign bad_len = (bit_cnt != 8'(CHAIN_BITS));

  // Shift / latch. On a coincident sclk+rclk edge the latch takes the
  // pre-shift value (non-blocking read of shift_q) and the shifted-in bit
  // is counted towards the next frame.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      shift_q     <= '0;
      par_out     <= '0;
      bit_cnt     <= '0;
      latch_pulse <= 1'b0;
      frame_err   <= 1'b0;
      err_cnt     <= '0;
    end else begin
      latch_pulse <= rclk_rise;
      if (sclk_rise)
        shift_q <= {shift_q[CHAIN_BITS-2:0], sdio_s};
      if (rclk_rise) begin
        par_out   <= shift_q;
        frame_err <= bad_len;
        bit_cnt   <= sclk_rise ? 8'd1 : 8'd0;
        if (bad_len && err_cnt != 8'hFF)
          err_cnt <= err_cnt + 8'd1;
      end else if (sclk_rise && bit_cnt != 8'hFF) begin
        bit_cnt <= bit_cnt + 8'd1;
      end
    end
  end

  // Digit decode of the latched word: valid only for exactly one low bit.
  logic [SEL_BITS-1:0] sel;
  logic [SEG_BITS-1:0] seg;
  logic [CNT_W-1:0]    zero_cnt;
  logic [IDX_W-1:0]    zero_idx;
  logic                sel_ok;

  assign sel = par_out[CHAIN_BITS-1:SEG_BITS];
  assign seg = par_out[SEG_BITS-1:0];

  always_comb begin
    zero_cnt = '0;
    zero_idx = '0;
    for (int i = 0; i < SEL_BITS; i++) begin
      if (!sel[i]) begin
        zero_cnt = zero_cnt + CNT_W'(1);
        zero_idx = IDX_W'(i);
      end
    end
  end
  assign sel_ok = (zero_cnt == CNT_W'(1));

  logic [SEL_BITS-1:0][SEG_BITS-1:0] mem;
  assign digits_out = mem;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mem       <= '1;
      digit_idx <= '0;
      digit_upd <= 1'b0;
    end else begin
      digit_upd <= 1'b0;
      if (latch_pulse && sel_ok) begin
        mem[zero_idx] <= seg;
        digit_idx     <= zero_idx;
        digit_upd     <= 1'b1;
      end
    end
  end
endmodule
